// File: rtl/ddr3_tg_pkg.sv
// ddr3_tg_pkg: shared types, constants and the data-pattern helper for the
// DDR3 traffic generator (ddr3_traffic_gen and ddr3_tg_watchdog).
package ddr3_tg_pkg;

    localparam logic [3:0] CMD_READ  = 4'b0001;
    localparam logic [3:0] CMD_WRITE = 4'b0010;
    localparam int         BEATS_PER_CMD = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_WR_CMD,
        ST_WR_DATA,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_DONE
    } tg_state_e;

    // Beat pattern: low word is the complement of the high word, so every data
    // bit toggles across the two halves of the 64-bit beat.
    function automatic logic [63:0] tg_pattern(input logic [31:0] seed,
                                               input logic [25:0] a,
                                               input logic        b);
        logic [31:0] w;
        w = seed ^ {5'b0, a, b};
        return {w, ~w};
    endfunction

endpackage

// File: rtl/ddr3_tg_watchdog.sv
// ddr3_tg_watchdog: free-running cycle counter that flags expire once it has
// counted TIMEOUT-1 cycles since the last clear.
//   clk    in  clock
//   rstn   in  synchronous active-low reset
//   clr    in  restart the count from zero
//   expire out counter reached TIMEOUT-1 (holds until cleared)
module ddr3_tg_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (!expire)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ddr3_traffic_gen.sv
// ddr3_traffic_gen: write pass then read-back-and-compare pass over
// NUM_CMDS BL8 commands starting at BASE_ADDR, on the controller local bus.
//   start/init_done          run control from top level / controller
//   cmd, cmd_valid, cmd_rdy, addr, cmd_burst_cnt, ofly_burst_len   command bus
//   write_data, data_mask, datain_rdy                              write bus
//   read_data, read_data_valid                                     read bus
//   busy, done, pass, err_count, first_err_addr, timeout           status
module ddr3_traffic_gen
    import ddr3_tg_pkg::*;
#(
    parameter int          NUM_CMDS  = 256,
    parameter logic [25:0] BASE_ADDR = 26'd0,
    parameter logic [31:0] SEED      = 32'hA5C3_0F1E,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        init_done,
    output logic [3:0]  cmd,
    output logic        cmd_valid,
    input  logic        cmd_rdy,
    output logic [25:0] addr,
    output logic [4:0]  cmd_burst_cnt,
    output logic        ofly_burst_len,
    output logic [63:0] write_data,
    output logic [7:0]  data_mask,
    input  logic        datain_rdy,
    input  logic [63:0] read_data,
    input  logic        read_data_valid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [25:0] first_err_addr,
    output logic        timeout
);
    localparam int         IW       = 22;
    localparam logic       LAST_BEAT = 1'(BEATS_PER_CMD - 1);

    tg_state_e     state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [25:0]   addr_q, addr_d;
    logic [63:0]   write_data_q, write_data_d;
    logic          beat_q, beat_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
    logic [15:0]   err_q, err_d;
    logic [25:0]   fea_q, fea_d;
    logic          wd_clr, wd_expire, active, last_cmd;

    assign active   = (state_q == ST_WR_CMD) || (state_q == ST_WR_DATA) ||
                      (state_q == ST_RD_CMD) || (state_q == ST_RD_WAIT);
    assign last_cmd = (idx_q == IW'(NUM_CMDS - 1));

    ddr3_tg_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (wd_clr),
        .expire (wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cmd_valid_d  = cmd_valid_q;
        addr_d       = addr_q;
        write_data_d = write_data_q;
        beat_d       = beat_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        err_d        = err_q;
        fea_d        = fea_q;
        wd_clr       = 1'b0;

        case (state_q)
            ST_IDLE: if (start) begin
                done_d = 1'b0; pass_d = 1'b0; timeout_d = 1'b0;
                err_d = '0; fea_d = '0; busy_d = 1'b1;
                addr_d = BASE_ADDR; idx_d = '0; beat_d = 1'b0;
                state_d = ST_WAIT_INIT;
            end
            ST_WAIT_INIT: if (init_done) begin
                cmd_valid_d = 1'b1; cmd_d = CMD_WRITE; state_d = ST_WR_CMD;
            end
            ST_WR_CMD: if (cmd_rdy) begin
                cmd_valid_d = 1'b0; beat_d = 1'b0;
                write_data_d = tg_pattern(SEED, addr_q, 1'b0);
                state_d = ST_WR_DATA; wd_clr = 1'b1;
            end
            ST_WR_DATA: if (datain_rdy) begin
                wd_clr = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    beat_d = 1'b0; cmd_valid_d = 1'b1;
                    if (last_cmd) begin
                        idx_d = '0; addr_d = BASE_ADDR; cmd_d = CMD_READ; state_d = ST_RD_CMD;
                    end else begin
                        idx_d = idx_q + IW'(1); addr_d = addr_q + 26'd8;
                        cmd_d = CMD_WRITE; state_d = ST_WR_CMD;
                    end
                end else begin
                    beat_d = 1'b1;
                    write_data_d = tg_pattern(SEED, addr_q, 1'b1);
                end
            end
            ST_RD_CMD: if (cmd_rdy) begin
                cmd_valid_d = 1'b0; beat_d = 1'b0; state_d = ST_RD_WAIT; wd_clr = 1'b1;
            end
            ST_RD_WAIT: if (read_data_valid) begin
                wd_clr = 1'b1;
                if (read_data != tg_pattern(SEED, addr_q, beat_q)) begin
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    // err_count never returns to zero inside a run, so zero
                    // marks the first mismatch.
                    if (err_q == 16'd0) fea_d = addr_q;
                end
                if (beat_q == LAST_BEAT) begin
                    beat_d = 1'b0;
                    if (last_cmd) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1); addr_d = addr_q + 26'd8;
                        cmd_valid_d = 1'b1; cmd_d = CMD_READ; state_d = ST_RD_CMD;
                    end
                end else begin
                    beat_d = 1'b1;
                end
            end
            ST_DONE: if (start) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides the normal transition; a mismatch in the same cycle
        // has already been counted above.
        if (active && (wd_expire || !init_done)) begin
            timeout_d = 1'b1; cmd_valid_d = 1'b0; state_d = ST_DONE;
        end

        if (state_d == ST_DONE && state_q != ST_DONE) begin
            busy_d = 1'b0; done_d = 1'b1;
            pass_d = (err_d == 16'd0) && !timeout_d;
        end

        if (state_d != state_q || !active) wd_clr = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;      cmd_q <= '0;       cmd_valid_q <= 1'b0;
            addr_q <= BASE_ADDR;     write_data_q <= '0; beat_q <= 1'b0;
            idx_q <= '0;             busy_q <= 1'b0;    done_q <= 1'b0;
            pass_q <= 1'b0;          timeout_q <= 1'b0; err_q <= '0;
            fea_q <= '0;
        end else begin
            state_q <= state_d;      cmd_q <= cmd_d;    cmd_valid_q <= cmd_valid_d;
            addr_q <= addr_d;        write_data_q <= write_data_d; beat_q <= beat_d;
            idx_q <= idx_d;          busy_q <= busy_d;  done_q <= done_d;
            pass_q <= pass_d;        timeout_q <= timeout_d; err_q <= err_d;
            fea_q <= fea_d;
        end
    end

    assign cmd            = cmd_q;
    assign cmd_valid      = cmd_valid_q;
    assign addr           = addr_q;
    assign write_data     = write_data_q;
    assign cmd_burst_cnt  = 5'd1;
    assign ofly_burst_len = 1'b0;
    assign data_mask      = 8'h00;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = fea_q;
    assign timeout        = timeout_q;
endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// tb_ddr3_traffic_gen: controller model + command/data scoreboard for
// ddr3_traffic_gen (NUM_CMDS=4, TIMEOUT=16).
module tb_ddr3_traffic_gen;
    localparam logic [31:0] SEED = 32'hA5C3_0F1E;
    localparam logic [3:0]  CW   = 4'b0010;
    localparam logic [3:0]  CR   = 4'b0001;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, init_done = 1'b1;
    logic [3:0] cmd; logic cmd_valid; logic cmd_rdy = 1'b0;
    logic [25:0] addr; logic [4:0] cmd_burst_cnt; logic ofly_burst_len;
    logic [63:0] write_data; logic [7:0] data_mask; logic datain_rdy = 1'b0;
    logic [63:0] read_data = '0; logic read_data_valid = 1'b0;
    logic busy, done, pass, timeout; logic [15:0] err_count; logic [25:0] first_err_addr;

    ddr3_traffic_gen #(.NUM_CMDS(4), .BASE_ADDR(26'd0), .SEED(SEED), .TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .init_done(init_done),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy), .addr(addr),
        .cmd_burst_cnt(cmd_burst_cnt), .ofly_burst_len(ofly_burst_len),
        .write_data(write_data), .data_mask(data_mask), .datain_rdy(datain_rdy),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .timeout(timeout));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [25:0] a, input logic b);
        logic [31:0] w;
        w = SEED ^ {5'b0, a, b};
        return {w, ~w};
    endfunction

    // model configuration (written by the stimulus process only)
    int stall_cmd = 0;
    bit toggle_drdy = 0, drdy_stall = 0, no_read = 0, corrupt_en = 0;
    // model bookkeeping
    logic [29:0] exp_cq[$];
    logic [63:0] exp_wq[$];
    logic [63:0] mem[int];
    int wr_acc = 0, rd_acc = 0, rd_beats = 0, stall_cnt = 0, wbeats = 0, rbeats = 0, rdelay = 0;
    longint cyc = 0, acc_cyc = 0;
    bit pend = 0, wpend = 0, tog = 0;
    logic [29:0] pend_val; logic [63:0] wpend_val;
    logic [25:0] cur_wa, cur_ra;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: drives inputs at negedge for the next posedge, so a
    // handshake seen here is the one the DUT samples at the coming edge.
    always @(negedge clk) begin
        if (!rstn) begin
            cmd_rdy = 0; datain_rdy = 0; read_data_valid = 0;
            wbeats = 0; rbeats = 0; pend = 0; wpend = 0; stall_cnt = 0; tog = 0;
            exp_wq.delete();
        end else begin
            datain_rdy = 0;
            if (wpend) chk("wdata_hold", write_data, wpend_val);
            wpend = 0;
            if (wbeats > 0 && !drdy_stall) begin
                tog = ~tog;
                if (!toggle_drdy || tog) begin
                    datain_rdy = 1;
                    if (exp_wq.size() == 0) chk("wdata_extra", 1, 0);
                    else chk("wdata", write_data, exp_wq.pop_front());
                    mem[int'({cur_wa, (wbeats == 1)})] = write_data;
                    wbeats--;
                end else begin
                    wpend = 1; wpend_val = write_data;
                end
            end
            read_data_valid = 0;
            if (rbeats > 0) begin
                if (rdelay > 0) rdelay--;
                else begin
                    automatic logic b = (rbeats == 1);
                    automatic int key = int'({cur_ra, b});
                    read_data = mem.exists(key) ? mem[key] : 64'h0;
                    if (corrupt_en && ((cur_ra == 26'd16 && b) || (cur_ra == 26'd24 && !b)))
                        read_data = read_data ^ 64'h100;
                    read_data_valid = 1; rbeats--; rd_beats++;
                end
            end
            cmd_rdy = 0;
            if (pend) chk("cmd_hold", {cmd_valid, cmd, addr}, {1'b1, pend_val});
            pend = 0;
            if (cmd_valid) begin
                if (stall_cnt < stall_cmd) begin
                    stall_cnt++; pend = 1; pend_val = {cmd, addr};
                end else begin
                    stall_cnt = 0; cmd_rdy = 1;
                    if (exp_cq.size() == 0) chk("cmd_extra", 1, 0);
                    else chk("cmd", {cmd, addr}, exp_cq.pop_front());
                    if (cmd == CW) begin
                        cur_wa = addr; wbeats = 2; wr_acc++;
                        exp_wq.push_back(pat(addr, 1'b0));
                        exp_wq.push_back(pat(addr, 1'b1));
                    end else begin
                        cur_ra = addr; rd_acc++; acc_cyc = cyc;
                        if (!no_read) begin rbeats = 2; rdelay = 2; end
                    end
                end
            end
        end
    end

    task automatic tick(); @(posedge clk); #2; endtask

    task automatic pulse_start(); start = 1; tick(); start = 0; endtask

    task automatic push_full();
        exp_cq.delete();
        for (int i = 0; i < 4; i++) exp_cq.push_back({CW, 26'(i * 8)});
        for (int i = 0; i < 4; i++) exp_cq.push_back({CR, 26'(i * 8)});
    endtask

    task automatic start_run();
        if (done) pulse_start();          // DONE -> IDLE
        pulse_start();
        chk("lat_wait", cmd_valid, 0);
        tick();
        chk("lat_cmd", {busy, cmd_valid}, 2'b11);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin tick(); n++; end
        chk("done_seen", done, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {cmd_valid, cmd, busy, done, pass, timeout}, '0);
        chk({tag, "_addr"}, addr, 26'd0);
        chk({tag, "_wd"}, write_data, 64'h0);
        chk({tag, "_err"}, {err_count, first_err_addr}, '0);
    endtask

    task automatic chk_fixed();
        chk("fixed", {cmd_burst_cnt, ofly_burst_len, data_mask}, {5'd1, 1'b0, 8'h00});
    endtask

    initial begin
        int base, n;
        longint lat;
        tick(); tick(); tick();
        chk_reset("rst");
        rstn = 1; tick();

        // 1: always-ready controller, clean data
        push_full(); base = rd_beats;
        start_run(); wait_done(300);
        chk("t1_status", {busy, pass, timeout}, 3'b010);
        chk("t1_err", err_count, 0);
        chk("t1_cq", exp_cq.size(), 0);
        chk("t1_beats", rd_beats - base, 8);
        chk_fixed();

        // 2: cmd_rdy stalled 5 cycles, datain_rdy toggling
        stall_cmd = 5; toggle_drdy = 1; push_full();
        start_run(); wait_done(600);
        chk("t2_status", {pass, timeout, err_count}, {1'b1, 1'b0, 16'd0});
        chk("t2_cq", exp_cq.size(), 0);
        stall_cmd = 0; toggle_drdy = 0;

        // 3: corrupted read beats
        corrupt_en = 1; push_full();
        start_run(); wait_done(300);
        chk("t3_err", err_count, 2);
        chk("t3_fea", first_err_addr, 26'd16);
        chk("t3_pass", {pass, timeout}, 2'b00);
        corrupt_en = 0;

        // 4: reads never answered -> watchdog abort
        no_read = 1; exp_cq.delete();
        for (int i = 0; i < 4; i++) exp_cq.push_back({CW, 26'(i * 8)});
        exp_cq.push_back({CR, 26'd0});
        start_run(); wait_done(300);
        lat = cyc - acc_cyc - 1;
        chk("t4_lat_le16", (lat <= 16), 1);
        chk("t4_status", {timeout, pass, cmd_valid, busy}, 4'b1000);
        no_read = 0;

        // 5: init_done drops in WR_DATA; extra start while busy is ignored
        drdy_stall = 1; exp_cq.delete(); exp_cq.push_back({CW, 26'd0});
        base = wr_acc;
        start_run();
        n = 0;
        while (wr_acc == base && n < 50) begin tick(); n++; end
        chk("t5_wr_acc", wr_acc - base, 1);
        pulse_start();
        chk("t5_start_ign", {busy, done, cmd_valid}, 3'b100);
        init_done = 0; tick();
        chk("t5_abort", {done, timeout, pass, busy, cmd_valid}, 5'b11000);
        init_done = 1;
        rstn = 0; tick(); tick(); rstn = 1; drdy_stall = 0; tick();

        // 6: reset mid-RD_WAIT, then a fresh clean run
        push_full(); base = rd_acc;
        start_run();
        n = 0;
        while (rd_acc == base && n < 300) begin tick(); n++; end
        chk("t6_rd_acc", rd_acc - base, 1);
        tick();
        rstn = 0; tick();
        chk_reset("t6_rst");
        rstn = 1; tick();
        push_full();
        start_run(); wait_done(300);
        chk("t6_status", {pass, timeout, err_count}, {1'b1, 1'b0, 16'd0});
        chk("t6_cq", exp_cq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
